// File: rtl/vdic_dut_pkg.sv
// rtl/vdic_dut_pkg.sv - shared command, FSM and data-mode types for the VDIC DUT and its frame generator
package vdic_dut_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'b000,
    CMD_ADD = 3'b001,
    CMD_AND = 3'b010,
    CMD_XOR = 3'b011,
    CMD_OR  = 3'b100,
    CMD_SUB = 3'b101
  } command_t;

  typedef enum logic [2:0] {IDLE, PICK, DATA, CMD, GAP} fsm_state_t;

  typedef enum logic [1:0] {ZEROS, ONES, RANDOM} data_mode_t;

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic command_t decode_cmd(input logic [2:0] bits);
    command_t c;
    case (bits)
      3'b001:  c = CMD_ADD;
      3'b010:  c = CMD_AND;
      3'b011:  c = CMD_XOR;
      3'b100:  c = CMD_OR;
      3'b101:  c = CMD_SUB;
      default: c = CMD_NOP;
    endcase
    return c;
  endfunction

  function automatic data_mode_t decode_mode(input logic [1:0] bits);
    data_mode_t m;
    case (bits)
      2'b00:   m = ZEROS;
      2'b11:   m = ONES;
      default: m = RANDOM;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vdic_frame_gen_if.sv
// rtl/vdic_frame_gen_if.sv - valid/ready word stream between the frame generator and its sink
interface vdic_frame_gen_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W:0] word_o;
  logic            word_valid_o;
  logic            word_ready_i;

  modport master (output word_o, word_valid_o, input word_ready_i);
  modport slave  (input word_o, word_valid_o, output word_ready_i);
endinterface

// File: rtl/vdic_lfsr.sv
// rtl/vdic_lfsr.sv - Galois LFSR that steps only when adv_i is high; an all-zero seed becomes 1
module vdic_lfsr
  import vdic_dut_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv_i,
  output logic [WIDTH-1:0] value_o
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS);
  localparam logic [WIDTH-1:0] INIT = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] value_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= INIT;
    end else if (adv_i) begin
      value_q <= (value_q >> 1) ^ (value_q[0] ? TAPS : '0);
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/vdic_frame_gen.sv
// rtl/vdic_frame_gen.sv - random command/data frame stream generator for the VDIC DUT
// Optional reset-request injection: define VDIC_FRAME_GEN_RESET_INJ_EN.
module vdic_frame_gen
  import vdic_dut_pkg::*;
#(
  parameter int          DATA_W   = 8,
  parameter int          MIN_SIZE = 1,
  parameter int          MAX_SIZE = 9,
  parameter logic [31:0] SEED     = 32'hACE1_0001
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic [15:0]             num_frames_i,
  vdic_frame_gen_if.master        stream,
  output logic                    frame_done_o,
  output logic                    busy_o,
  output logic                    rst_req_o
);

  localparam int SPAN = MAX_SIZE - MIN_SIZE + 1;

  fsm_state_t        state, state_nx;
  logic [31:0]       lfsr;
  logic              lfsr_adv;
  command_t          cmd_q;
  data_mode_t        mode_q;
  logic [7:0]        size_q, sent_q, size_pick;
  logic [15:0]       frame_cnt;
  logic              stop_q;
  logic [DATA_W:0]   word_q;
  logic              valid_q;
  logic              xfer;
  logic              run_end;
  logic [DATA_W-1:0] data_word;
  logic              unused_lfsr_bits;

  vdic_lfsr #(.WIDTH(32), .SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .adv_i   (lfsr_adv),
    .value_o (lfsr)
  );

  assign xfer      = valid_q && stream.word_ready_i;
  assign lfsr_adv  = (state == PICK) || ((state == DATA) && xfer);
  assign size_pick = 8'(MIN_SIZE + (int'(lfsr[15:8]) % SPAN));
  assign run_end   = stop_q || stop_i ||
                     ((num_frames_i != 16'd0) && (frame_cnt == num_frames_i));

  always_comb begin
    data_word = lfsr[DATA_W-1:0];
    case (mode_q)
      ZEROS:   data_word = '0;
      ONES:    data_word = '1;
      default: data_word = lfsr[DATA_W-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i) state_nx = PICK;
      PICK:    state_nx = DATA;
      DATA:    if (xfer && (sent_q + 8'd1 == size_q)) state_nx = CMD;
      CMD:     if (xfer) state_nx = GAP;
      GAP:     state_nx = run_end ? IDLE : PICK;
      default: state_nx = IDLE;
    endcase
  end

  // The word register loads in the cycle after it empties, so word_o never depends on ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q     <= CMD_NOP;
      mode_q    <= ZEROS;
      size_q    <= '0;
      sent_q    <= '0;
      frame_cnt <= '0;
      stop_q    <= 1'b0;
      word_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        stop_q <= 1'b0;
        if (start_i) frame_cnt <= '0;
      end else if (stop_i) begin
        stop_q <= 1'b1;
      end

      if (state == PICK) begin
        cmd_q  <= decode_cmd(lfsr[2:0]);
        mode_q <= decode_mode(lfsr[17:16]);
        size_q <= size_pick;
        sent_q <= '0;
      end

      if (xfer) begin
        valid_q <= 1'b0;
        if (state == DATA) sent_q <= sent_q + 8'd1;
        if (state == CMD)  frame_cnt <= frame_cnt + 16'd1;
      end else if (!valid_q && (state == DATA)) begin
        word_q  <= {1'b0, data_word};
        valid_q <= 1'b1;
      end else if (!valid_q && (state == CMD)) begin
        word_q  <= {1'b1, DATA_W'(cmd_q)};
        valid_q <= 1'b1;
      end
    end
  end

  assign stream.word_o       = word_q;
  assign stream.word_valid_o = valid_q;
  assign frame_done_o        = (state == CMD) && xfer;
  assign busy_o              = (state != IDLE);
  assign unused_lfsr_bits    = ^lfsr[31:18];

`ifdef VDIC_FRAME_GEN_RESET_INJ_EN
  assign rst_req_o = (state == PICK) && (lfsr[19:18] == 2'b00);
`else
  assign rst_req_o = 1'b0;
`endif

endmodule

// File: tb/tb_vdic_frame_gen.sv
// tb/tb_vdic_frame_gen.sv - scoreboard bench for vdic_frame_gen
module tb_vdic_frame_gen;

  localparam int          DATA_W   = 8;
  localparam int          MIN_SIZE = 2;
  localparam int          MAX_SIZE = 5;
  localparam logic [31:0] SEED     = 32'hACE1_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop;
  logic [15:0] num_frames;
  logic        frame_done, busy, rst_req;

  vdic_frame_gen_if #(.DATA_W(DATA_W)) sif ();

  vdic_frame_gen #(
    .DATA_W   (DATA_W),
    .MIN_SIZE (MIN_SIZE),
    .MAX_SIZE (MAX_SIZE),
    .SEED     (SEED)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .stop_i       (stop),
    .num_frames_i (num_frames),
    .stream       (sif),
    .frame_done_o (frame_done),
    .busy_o       (busy),
    .rst_req_o    (rst_req)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          run_len = 0;
  logic        f0 = 1'b1, f1 = 1'b1;
  logic        zeros_seen = 1'b0, ones_seen = 1'b0, rand_seen = 1'b0;
  logic        rst_req_seen = 1'b0;
  logic [8:0]  sb[$];
  logic [8:0]  seen[$];
  logic [8:0]  w_mon, e_mon;
  logic [31:0] m_lfsr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic push_frames(input int n);
    for (int f = 0; f < n; f++) begin
      logic [31:0] l;
      logic [2:0]  cmd;
      logic [1:0]  mode;
      logic [7:0]  d;
      int          size;
      l    = m_lfsr;
      cmd  = (l[2:0] <= 3'd5) ? l[2:0] : 3'd0;
      size = MIN_SIZE + int'(l[15:8]) % (MAX_SIZE - MIN_SIZE + 1);
      mode = l[17:16];
      m_lfsr = m_step(m_lfsr);
      for (int i = 0; i < size; i++) begin
        d = (mode == 2'b00) ? 8'h00 : (mode == 2'b11) ? 8'hFF : m_lfsr[7:0];
        sb.push_back({1'b0, d});
        m_lfsr = m_step(m_lfsr);
      end
      sb.push_back({1'b1, 5'b0, cmd});
    end
  endtask

  // Monitor: samples on the falling edge, a transfer completes on the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0; f0 = 1'b1; f1 = 1'b1;
    end else begin
      if (rst_req) rst_req_seen = 1'b1;
      if (frame_done) done_cnt++;
      if (sif.word_valid_o && sif.word_ready_i) begin
        w_mon = sif.word_o;
        seen.push_back(w_mon);
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_word actual=%0h required=none", w_mon);
        end else begin
          e_mon = sb.pop_front();
          check("stream_word", w_mon, e_mon);
        end
        check("done_pulse", frame_done, w_mon[8]);
        if (w_mon[8]) begin
          check("cmd_range", w_mon[7:0] <= 8'd5, 1);
          check("frame_size", (run_len >= MIN_SIZE) && (run_len <= MAX_SIZE), 1);
          if (f0) zeros_seen = 1'b1;
          else if (f1) ones_seen = 1'b1;
          else rand_seen = 1'b1;
          run_len = 0; f0 = 1'b1; f1 = 1'b1;
        end else begin
          run_len++;
          if (w_mon[7:0] != 8'h00) f0 = 1'b0;
          if (w_mon[7:0] != 8'hFF) f1 = 1'b0;
        end
      end
    end
  end

  task automatic start_run(input logic [15:0] n);
    num_frames = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy && k < budget) begin @(posedge clk); #1; k++; end
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k = 0;
    while (!sif.word_valid_o && k < budget) begin @(posedge clk); #1; k++; end
    check({name, "_valid"}, sif.word_valid_o, 1);
  endtask

  task automatic check_first_frame(input string name);
    logic [8:0] ref_words[3];
    ref_words = '{9'h003, 9'h002, 9'h101};
    for (int i = 0; i < 3; i++)
      check(name, (seen.size() > i) ? seen[i] : 9'h1FF, ref_words[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    int         k;
    int         n0;
    logic [8:0] held;

    rst = 1'b1; start = 1'b0; stop = 1'b0; num_frames = '0;
    sif.word_ready_i = 1'b0;
    m_lfsr = SEED;
    repeat (3) @(posedge clk);
    #1;
    check("rst_word",    sif.word_o, 0);
    check("rst_valid",   sif.word_valid_o, 0);
    check("rst_busy",    busy, 0);
    check("rst_done",    frame_done, 0);
    check("rst_rst_req", rst_req, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // three frames, sink always ready
    done_cnt = 0; seen.delete();
    sif.word_ready_i = 1'b1;
    push_frames(3);
    n0 = sb.size();
    start_run(16'd3);
    lat = 0;
    while (!sif.word_valid_o && lat < 10) begin @(posedge clk); #1; lat++; end
    check("first_valid_latency", lat, 2);
    wait_idle(200, "run3");
    check("run3_frames", done_cnt, 3);
    check("run3_words", seen.size(), n0);
    check("run3_sb_empty", sb.size(), 0);
    check_first_frame("run3_first_frame");

    // back-pressure: five stalled cycles then transfer
    done_cnt = 0;
    sif.word_ready_i = 1'b0;
    push_frames(2);
    start_run(16'd2);
    wait_valid(20, "stall");
    held = sif.word_o;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", sif.word_valid_o, 1);
      check("stall_word", sif.word_o, held);
    end
    n0 = seen.size();
    sif.word_ready_i = 1'b1;
    @(posedge clk); #1;
    check("stall_release_xfer", seen.size(), n0 + 1);
    wait_idle(200, "stall");
    check("stall_frames", done_cnt, 2);
    check("stall_sb_empty", sb.size(), 0);

    // reset while the second data word waits, then replay from the seed
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    m_lfsr = SEED; sb.delete(); seen.delete();
    sif.word_ready_i = 1'b0;
    push_frames(1);
    start_run(16'd1);
    wait_valid(20, "mid1");
    sif.word_ready_i = 1'b1;
    @(posedge clk); #1;
    sif.word_ready_i = 1'b0;
    wait_valid(20, "mid2");
    check("mid_words_before_rst", seen.size(), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid", sif.word_valid_o, 0);
    check("mid_rst_busy", busy, 0);
    rst = 1'b0;
    m_lfsr = SEED; sb.delete(); seen.delete();
    done_cnt = 0;
    push_frames(1);
    sif.word_ready_i = 1'b1;
    start_run(16'd1);
    wait_idle(200, "replay");
    check("replay_frames", done_cnt, 1);
    check("replay_sb_empty", sb.size(), 0);
    check_first_frame("replay_first_frame");

    // continuous run stopped during frame 50
    done_cnt = 0;
    push_frames(50);
    start_run(16'd0);
    k = 0;
    while (done_cnt < 49 && k < 5000) begin @(posedge clk); #1; k++; end
    check("stop_reach49", done_cnt, 49);
    repeat (2) begin @(posedge clk); #1; end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_idle(200, "stop");
    check("stop_frames", done_cnt, 50);
    check("stop_sb_empty", sb.size(), 0);

    // long run for range and data-mode coverage
    done_cnt = 0;
    push_frames(1000);
    start_run(16'd1000);
    wait_idle(30000, "long");
    check("long_frames", done_cnt, 1000);
    check("long_sb_empty", sb.size(), 0);
    check("modes_seen", {zeros_seen, ones_seen, rand_seen}, 3'b111);
`ifndef VDIC_FRAME_GEN_RESET_INJ_EN
    check("rst_req_never", rst_req_seen, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vdic_frame_gen.md
VDIC_FRAME_GEN -- requirements
Module: vdic_frame_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the data byte width.
REQ-002 SHALL have parameter MIN_SIZE, default 1, meaning the minimum number of data words per frame.
REQ-003 SHALL have parameter MAX_SIZE, default 9, meaning the maximum number of data words per frame (MIN_SIZE<=MAX_SIZE<=255).
REQ-004 SHALL have parameter SEED, default 32'hACE1_0001, meaning the LFSR reset value (0 replaced by 1).
REQ-005 SHALL have port clk  input  1  meaning the single clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  meaning the asynchronous, active-high reset.
REQ-007 SHALL have port start_i  input  1  meaning a one-cycle run request, sampled in IDLE only.
REQ-008 SHALL have port stop_i  input  1  meaning to end the run after the current frame completes.
REQ-009 SHALL have port num_frames_i  input  16  meaning frames per run, with 0 = continuous until stop_i.
REQ-010 SHALL have port word_o  output  DATA_W+1  meaning the stream word; MSB=1 marks a command word, MSB=0 a data word.
REQ-011 SHALL have port word_valid_o  output  1  meaning word_o is valid.
REQ-012 SHALL have port word_ready_i  input  1  meaning the sink accepts the word; transfer = valid&&ready.
REQ-013 SHALL have port frame_done_o  output  1  meaning a one-cycle pulse when a command word is transferred.
REQ-014 SHALL have port busy_o  output  1  meaning high in any state except IDLE.
REQ-015 SHALL have port rst_req_o  output  1  meaning a one-cycle DUT-reset request (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, PICK, DATA, CMD, GAP.
REQ-017 IDLE->PICK SHALL occur when start_i=1; first word_valid_o rises 2 cycles after start_i is sampled.
REQ-018 PICK SHALL take one cycle and draw from LFSR: cmd = lfsr[2:0], mapped 000/110/111 to CMD_NOP, 001 to CMD_ADD, 010 to CMD_AND, 011 to CMD_XOR, 100 to CMD_OR, 101 to CMD_SUB.
REQ-019 PICK SHALL set size = MIN_SIZE + (lfsr[15:8] mod (MAX_SIZE-MIN_SIZE+1)) and mode = lfsr[17:16].
REQ-020 DATA SHALL emit size words {1'b0,d}: d=0 when mode=00, all-ones when mode=11, otherwise lfsr[DATA_W-1:0] captured per word.
REQ-021 CMD SHALL emit one word {1'b1, cmd zero-extended/truncated to DATA_W}.
REQ-022 The LFSR SHALL be a 32-bit Galois LFSR (taps 32,22,2,1) and SHALL advance exactly once per PICK cycle and once per data-word transfer, never otherwise.
REQ-023 Once word_valid_o rises, word_o SHALL stay stable and valid SHALL stay high until transfer; no combinational path from word_ready_i to word_valid_o.
REQ-024 GAP SHALL last one cycle with valid low, then go to IDLE if frame count reached num_frames_i (non-zero) or stop was latched, else to PICK.
REQ-025 stop_i SHALL be latched in any busy state and cleared on entering IDLE; start_i while busy SHALL be ignored.
REQ-026 The frame counter SHALL be 16 bits, cleared on start; with num_frames_i=0 it SHALL wrap without terminating the run.

Reset
REQ-027 On rst: state=IDLE, word_o=0, word_valid_o=0, frame_done_o=0, busy_o=0, rst_req_o=0, LFSR=SEED (or 1), counters and stop latch=0.
REQ-028 Reset mid-frame SHALL abandon the frame immediately with no partial command word emitted.

Configuration
REQ-029 With macro VDIC_FRAME_GEN_RESET_INJ_EN defined, rst_req_o SHALL pulse for the PICK cycle when lfsr[19:18]==00.
REQ-030 Without VDIC_FRAME_GEN_RESET_INJ_EN, rst_req_o SHALL be constant 0; the word stream SHALL be bit-identical in both builds.

Structure
REQ-031 command_t SHALL come from vdic_dut_pkg; fsm_state_t and data_mode_t (ZEROS, ONES, RANDOM) SHALL be added there.
REQ-032 The LFSR SHALL be a sub-module, vdic_lfsr (parameters WIDTH, SEED; ports clk, rst, adv_i, value_o).

Verification
REQ-033 MIN_SIZE=MAX_SIZE=2, num_frames_i=3, ready=1 -> exactly 9 words (D,D,C x3), 3 frame_done_o pulses, busy_o low 1 cycle after the last GAP.
REQ-034 Hold ready low 5 cycles on a valid word -> word_o unchanged and valid high all 5 cycles; transfer on cycle 6.
REQ-035 Assert rst during the 2nd data word -> next cycle valid=0, busy=0; restart reproduces the first frame exactly.
REQ-036 SEED=0 vs SEED=1 -> identical streams over 100 frames.
REQ-037 num_frames_i=0, stop_i at frame 50 -> run ends after frame 50's GAP; 1000 frames: cmd and size stay in legal ranges, all three data modes seen.
REQ-038 Compile with and without VDIC_FRAME_GEN_RESET_INJ_EN over 1000 frames -> identical word streams; rst_req_o never asserts without the macro.
